// File: rtl/led_pattern_sequencer_if.sv
// Pattern-sequencer signal bundle: slow Tick/En/Mode control in, LED bank and status out.
// The master side drives the controls; the slave side is the sequencer itself.
interface led_pattern_sequencer_if #(
    parameter int LED_W = 8
);
    // Tick is a free-running level (both edges matter) with no handshake; En gates whether a
    // detected edge is accepted, and Step pulses for exactly one Clkin cycle per accepted edge.
    logic             Tick;
    logic             En;
    logic [1:0]       Mode;
    logic [LED_W-1:0] Leds;
    logic             Step;
    logic [1:0]       CurMode;

    modport master (output Tick, En, Mode, input Leds, Step, CurMode);
    modport slave  (input Tick, En, Mode, output Leds, Step, CurMode);
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: synchronizes the divider's slow toggle, turns each edge into a step and
// advances a SHIFT/BOUNCE/COUNT/BLINK pattern. Optional breathing PWM via `define BREATH_PWM_EN.
module led_pattern_sequencer #(
    parameter int LED_W = 8,
    parameter int PWM_W = 8
) (
    input  logic                   Clkin,
    input  logic                   Rstn,
`ifdef BREATH_PWM_EN
    input  logic [PWM_W-1:0]       Duty,
`endif
    led_pattern_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_COUNT  = 2'b10,
        MODE_BLINK  = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [LED_W-1:0] LedOne = LED_W'(1);

    if (LED_W < 2 || PWM_W < 1) begin : g_param_check
        $error("led_pattern_sequencer: LED_W must be >= 2 and PWM_W >= 1");
    end

    logic             s0_q, s1_q, prev_q;
    logic             tick_edge;
    logic [LED_W-1:0] pat_q, pat_d;
    mode_e            mode_q, mode_d, req_mode;
    dir_e             dir_q, dir_d;
    logic             step_q, step_d;
    logic             go_left;

    assign tick_edge = s1_q ^ prev_q;
    assign req_mode  = mode_e'(bus.Mode);
    // The end positions force the turn even if the stored direction disagrees.
    assign go_left   = pat_q[0] || (dir_q == DIR_LEFT && !pat_q[LED_W-1]);

    always_ff @(posedge Clkin or negedge Rstn) begin
        if (!Rstn) begin
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            prev_q <= 1'b0;
            pat_q  <= LedOne;
            mode_q <= MODE_SHIFT;
            dir_q  <= DIR_LEFT;
            step_q <= 1'b0;
        end else begin
            s0_q   <= bus.Tick;
            s1_q   <= s0_q;
            prev_q <= s1_q;
            pat_q  <= pat_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    always_comb begin
        pat_d  = pat_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        step_d = tick_edge & bus.En;
        if (step_d) begin
            if (req_mode != mode_q) begin
                mode_d = req_mode;
                dir_d  = DIR_LEFT;
                case (req_mode)
                    MODE_COUNT: pat_d = '0;
                    MODE_BLINK: pat_d = '1;
                    default:    pat_d = LedOne;
                endcase
            end else begin
                case (mode_q)
                    MODE_SHIFT: begin
                        if (!$onehot(pat_q)) pat_d = LedOne;
                        else                 pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                    end
                    MODE_BOUNCE: begin
                        if (!$onehot(pat_q)) begin
                            pat_d = LedOne;
                            dir_d = DIR_LEFT;
                        end else begin
                            pat_d = go_left ? (pat_q << 1) : (pat_q >> 1);
                            if (pat_d[LED_W-1])  dir_d = DIR_RIGHT;
                            else if (pat_d[0])   dir_d = DIR_LEFT;
                            else                 dir_d = go_left ? DIR_LEFT : DIR_RIGHT;
                        end
                    end
                    MODE_COUNT: pat_d = pat_q + LedOne;
                    default:    pat_d = ~pat_q;
                endcase
            end
        end
    end

    assign bus.Step    = step_q;
    assign bus.CurMode = mode_q;

`ifdef BREATH_PWM_EN
    logic [PWM_W-1:0] pc_q;

    always_ff @(posedge Clkin or negedge Rstn) begin
        if (!Rstn) pc_q <= '0;
        else       pc_q <= pc_q + 1'b1;
    end

    assign bus.Leds = pat_q & {LED_W{pc_q < Duty}};
`else
    assign bus.Leds = pat_q;
`endif
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed Tick toggles with literal expectations
// plus a step-count pattern model compared against the outputs on every cycle.
module tb_led_pattern_sequencer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;
    int   cyc;
    logic cmp_on = 1'b0;

    // Model: current pattern and the number of advances since that pattern was loaded.
    logic [1:0] m_mode = 2'b00;
    int         m_k = 0;
    logic       exp_step = 1'b0;

    logic [7:0] duty = 8'hff;

    logic [7:0] shift_exp  [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bounce_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                    8'h40, 8'h20};
    logic [7:0] blink_exp  [3]  = '{8'hff, 8'h00, 8'hff};

    led_pattern_sequencer_if #(.LED_W(W)) bus ();

    led_pattern_sequencer #(.LED_W(W), .PWM_W(8)) dut (
        .Clkin (clk),
        .Rstn  (rstn),
`ifdef BREATH_PWM_EN
        .Duty  (duty),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_leds();
        int p;
        case (m_mode)
            2'b00: return 8'(1 << (m_k % W));
            2'b01: begin
                p = m_k % (2 * W - 2);
                return 8'(1 << ((p < W) ? p : (2 * W - 2 - p)));
            end
            2'b10: return 8'(m_k % 256);
            default: return ((m_k % 2) == 1) ? 8'h00 : 8'hff;
        endcase
    endfunction

    function automatic logic [7:0] pwm_mask();
`ifdef BREATH_PWM_EN
        return ((cyc % 256) < int'(duty)) ? 8'hff : 8'h00;
`else
        return 8'hff;
`endif
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            check("leds",    {24'd0, bus.Leds},    {24'd0, model_leds() & pwm_mask()});
            check("step",    {31'd0, bus.Step},    {31'd0, exp_step});
            check("curmode", {30'd0, bus.CurMode}, {30'd0, m_mode});
        end
    end

    // One Tick toggle: change at a falling edge, so the next rising edge is P0 and the step lands at P2.
    task automatic tick_step(input logic chk, input logic [7:0] lit);
        @(negedge clk);
        bus.Tick = ~bus.Tick;
        repeat (3) @(posedge clk);
        #1;
        if (bus.En) begin
            if (bus.Mode != m_mode) begin
                m_mode = bus.Mode;
                m_k    = 0;
            end else begin
                m_k++;
            end
            exp_step = 1'b1;
        end
        if (chk) check("lit_leds", {24'd0, bus.Leds}, {24'd0, lit & pwm_mask()});
        @(posedge clk);
        #1;
        exp_step = 1'b0;
    endtask

    initial begin
        int hi;
        rstn     = 1'b0;
        bus.Tick = 1'b0;
        bus.En   = 1'b1;
        bus.Mode = 2'b00;
        cmp_on   = 1'b1;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        repeat (5) @(posedge clk);

        for (int i = 0; i < 3; i++) tick_step(1'b1, shift_exp[i]);

        // Asynchronous reset in the middle of a cycle, checked before any clock edge.
        @(posedge clk);
        #3;
        rstn     = 1'b0;
        bus.Tick = 1'b0;
        m_mode   = 2'b00;
        m_k      = 0;
        exp_step = 1'b0;
        #1;
        check("rst_leds",    {24'd0, bus.Leds},    32'h01);
        check("rst_step",    {31'd0, bus.Step},    32'h0);
        check("rst_curmode", {30'd0, bus.CurMode}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        repeat (10) @(posedge clk);

        for (int i = 0; i < 8; i++) tick_step(1'b1, shift_exp[i]);

        bus.Mode = 2'b01;
        for (int i = 0; i < 10; i++) tick_step(1'b1, bounce_exp[i]);

        bus.Mode = 2'b10;
        tick_step(1'b1, 8'h00);
        for (int i = 0; i < 256; i++) begin
            if (i == 0)        tick_step(1'b1, 8'h01);
            else if (i == 254) tick_step(1'b1, 8'hff);
            else if (i == 255) tick_step(1'b1, 8'h00);
            else               tick_step(1'b0, 8'h00);
        end

        bus.En   = 1'b0;
        bus.Mode = 2'b11;
        for (int i = 0; i < 4; i++) tick_step(1'b1, 8'h00);
        bus.En = 1'b1;
        for (int i = 0; i < 3; i++) tick_step(1'b1, blink_exp[i]);

`ifdef BREATH_PWM_EN
        duty = 8'd64;
        hi   = 0;
        repeat (256) begin
            @(negedge clk);
            #1;
            if (bus.Leds == 8'hff) hi++;
        end
        check("pwm_duty64_high", hi, 64);
        duty = 8'd0;
        repeat (256) @(negedge clk);
`else
        hi = 0;
`endif

        repeat (4) @(posedge clk);
        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
